// File: rtl/div16sx8s_seq_if.sv
// Handshake bundle for the sequential signed divider: operand request side and result side.
interface div16sx8s_seq_if #(
    parameter int DW = 16,
    parameter int VW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;
    logic          ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, ovf
    );
endinterface

// File: rtl/div16sx8s_seq.sv
// Radix-2 restoring signed divider, one quotient bit per clock, magnitudes in, signs patched at the end.
// Zero-divisor and MIN/-1 results take one pass through CALC so every result is registered there.
module div16sx8s_seq #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic             clk,
    input  logic             rst,
    div16sx8s_seq_if.slave   bus
);
    localparam int CW = $clog2(DW);
    localparam logic [1:0]    S_IDLE   = 2'd0;
    localparam logic [1:0]    S_CALC   = 2'd1;
    localparam logic [1:0]    S_DONE   = 2'd2;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [DW-1:0] Q_MAX    = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] Q_MIN    = {1'b1, {(DW-1){1'b0}}};
    localparam logic [VW-1:0] V_ZERO   = {VW{1'b0}};
    localparam logic [VW-1:0] V_NEG1   = {VW{1'b1}};

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] prem_q, prem_d;
    logic [VW:0]   dsr_q, dsr_d;
    logic          qneg_q, qneg_d;
    logic          rneg_q, rneg_d;
    logic          spc_dz_q, spc_dz_d;
    logic          spc_ovf_q, spc_ovf_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;

    logic [VW:0]   shifted_s;
    logic          ge_s;
    logic [VW-1:0] rmag_s;
    logic [DW-1:0] qmag_s;

    function automatic logic [DW:0] mag_dvd(input logic [DW-1:0] v);
        logic [DW:0] ext;
        ext = {v[DW-1], v};
        return v[DW-1] ? (~ext + {{DW{1'b0}}, 1'b1}) : ext;
    endfunction

    function automatic logic [VW:0] mag_dsr(input logic [VW-1:0] v);
        logic [VW:0] ext;
        ext = {v[VW-1], v};
        return v[VW-1] ? (~ext + {{VW{1'b0}}, 1'b1}) : ext;
    endfunction

    // One restore step on the current partial remainder; also the FSM next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        prem_d    = prem_q;
        dsr_d     = dsr_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        spc_dz_d  = spc_dz_q;
        spc_ovf_d = spc_ovf_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;

        // Partial remainder stays below |divisor| <= 2^(VW-1), so the shift never loses a bit.
        shifted_s = {prem_q, dvd_q[DW-1]};
        ge_s      = (shifted_s >= dsr_q);
        if (ge_s) begin
            rmag_s = VW'(shifted_s - dsr_q);
        end else begin
            rmag_s = VW'(shifted_s);
        end
        qmag_s = {dvd_q[DW-2:0], ge_s};

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d   = S_CALC;
                    cnt_d     = CNT_LAST;
                    dvd_d     = DW'(mag_dvd(bus.dividend));
                    dsr_d     = mag_dsr(bus.divisor);
                    prem_d    = V_ZERO;
                    qneg_d    = bus.dividend[DW-1] ^ bus.divisor[VW-1];
                    rneg_d    = bus.dividend[DW-1];
                    spc_dz_d  = (bus.divisor == V_ZERO);
                    spc_ovf_d = (bus.dividend == Q_MIN) && (bus.divisor == V_NEG1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (spc_dz_q || spc_ovf_q) begin
                    state_d   = S_DONE;
                    quot_d    = (spc_dz_q && rneg_q) ? Q_MIN : Q_MAX;
                    rem_d     = V_ZERO;
                    dz_d      = spc_dz_q;
                    ovf_d     = spc_ovf_q;
                    spc_dz_d  = 1'b0;
                    spc_ovf_d = 1'b0;
                end else begin
                    dvd_d  = qmag_s;
                    prem_d = rmag_s;
                    if (cnt_q == CNT_ZERO) begin
                        state_d = S_DONE;
                        quot_d  = qneg_q ? -qmag_s : qmag_s;
                        rem_d   = rneg_q ? -rmag_s : rmag_s;
                        dz_d    = 1'b0;
                        ovf_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            dvd_q     <= {DW{1'b0}};
            prem_q    <= V_ZERO;
            dsr_q     <= {(VW+1){1'b0}};
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            spc_dz_q  <= 1'b0;
            spc_ovf_q <= 1'b0;
            quot_q    <= {DW{1'b0}};
            rem_q     <= V_ZERO;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            prem_q    <= prem_d;
            dsr_q     <= dsr_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            spc_dz_q  <= spc_dz_d;
            spc_ovf_q <= spc_ovf_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_div16sx8s_seq.sv
// Bench for div16sx8s_seq: arithmetic reference model checked every cycle, plus directed literal vectors.
module tb_div16sx8s_seq;
    typedef struct packed {
        logic signed [15:0] q;
        logic signed [7:0]  r;
        logic               dz;
        logic               ovf;
    } res_t;

    typedef struct {
        int a; int b; int q; int r; int dz; int ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    div16sx8s_seq_if bus ();

    div16sx8s_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: C-style truncating division with the saturation rules.
    function automatic res_t model(input int a, input int b);
        res_t m;
        if (b == 0) begin
            m.q = (a >= 0) ? 16'sd32767 : -16'sd32768;
            m.r = 8'sd0; m.dz = 1'b1; m.ovf = 1'b0;
        end else if (a == -32768 && b == -1) begin
            m.q = 16'sd32767; m.r = 8'sd0; m.dz = 1'b0; m.ovf = 1'b1;
        end else begin
            m.q = 16'(a / b); m.r = 8'(a % b); m.dz = 1'b0; m.ovf = 1'b0;
        end
        return m;
    endfunction

    function automatic int lat_of(input res_t m);
        return (m.dz || m.ovf) ? 1 : 16;
    endfunction

    // Model state, advanced on each rising edge from the bench-driven inputs
    int   cyc = 0;
    int   acc = 0;
    logic busy = 1'b0;
    logic mon_en = 1'b0;
    res_t pend = '0;
    res_t shown = '0;
    int   n_acc = 0;
    int   n_out = 0;
    logic exp_ov;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            busy   <= 1'b0;
            shown  <= '0;
            mon_en <= 1'b1;
        end else if (!busy) begin
            if (bus.in_valid) begin
                busy  <= 1'b1;
                acc   <= cyc + 1;
                pend  <= model(int'($signed(bus.dividend)), int'($signed(bus.divisor)));
                n_acc <= n_acc + 1;
            end
        end else if (cyc + 1 - acc == lat_of(pend)) begin
            shown <= pend;
        end else if ((cyc + 1 - acc > lat_of(pend)) && bus.out_ready) begin
            busy  <= 1'b0;
            n_out <= n_out + 1;
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            exp_ov = busy && (cyc - acc >= lat_of(pend));
            chk("in_ready",  int'(bus.in_ready),  int'(!busy));
            chk("out_valid", int'(bus.out_valid), int'(exp_ov));
            chk("quotient",  int'($signed(bus.quotient)),  int'(shown.q));
            chk("remainder", int'($signed(bus.remainder)), int'(shown.r));
            chk("div_zero",  int'(bus.div_zero), int'(shown.dz));
            chk("ovf",       int'(bus.ovf),      int'(shown.ovf));
        end
    end

    task automatic send(input int a, input int b);
        int n;
        bus.dividend = 16'(a);
        bus.divisor  = 8'(b);
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Call right after the accept edge (+1); returns edges from accept to out_valid.
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) chk("result_timeout", 0, 1);
    endtask

    task automatic take(input int hold);
        repeat (hold) @(negedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic run_dir(input vec_t v);
        int lat;
        send(v.a, v.b);
        wait_valid(lat);
        chk("dir_latency", lat, (v.dz != 0 || v.ovf != 0) ? 1 : 16);
        chk("dir_q",   int'($signed(bus.quotient)),  v.q);
        chk("dir_r",   int'($signed(bus.remainder)), v.r);
        chk("dir_dz",  int'(bus.div_zero), v.dz);
        chk("dir_ovf", int'(bus.ovf),      v.ovf);
        take(0);
    endtask

    vec_t vt[11] = '{
        '{1000, 7, 142, 6, 0, 0},
        '{-1000, 7, -142, -6, 0, 0},
        '{1000, -7, -142, 6, 0, 0},
        '{32767, -128, -255, 127, 0, 0},
        '{-32768, -128, 256, 0, 0, 0},
        '{-32768, -1, 32767, 0, 0, 1},
        '{5, 0, 32767, 0, 1, 0},
        '{-5, 0, -32768, 0, 1, 0},
        '{-32768, 1, -32768, 0, 0, 0},
        '{-32768, 127, -258, -2, 0, 0},
        '{100, 3, 33, 1, 0, 0}
    };

    initial begin
        res_t m;
        int lat, a0, o0, a, b, sel;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend = 16'd0;
        bus.divisor = 8'd0;

        foreach (vt[i]) begin
            m = model(vt[i].a, vt[i].b);
            chk("model_q", int'(m.q), vt[i].q);
            chk("model_r", int'(m.r), vt[i].r);
        end

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_quotient", int'(bus.quotient), 0);
        chk("rst_flags", int'({bus.div_zero, bus.ovf}), 0);
        @(posedge clk);
        #1;

        foreach (vt[i]) run_dir(vt[i]);

        // Backpressure with a competing request held high through CALC and DONE
        send(1000, 7);
        bus.dividend = 16'd99;
        bus.divisor  = 8'd9;
        bus.in_valid = 1'b1;
        wait_valid(lat);
        chk("bp_latency", lat, 16);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_quotient", int'($signed(bus.quotient)), 142);
            chk("bp_remainder", int'($signed(bus.remainder)), 6);
        end
        take(0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_next_latency", lat, 16);
        chk("bp_next_q", int'($signed(bus.quotient)), 11);
        chk("bp_next_r", int'($signed(bus.remainder)), 0);
        take(1);

        // Reset in the middle of CALC discards the operation
        send(1000, 7);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", int'(bus.in_ready), 1);
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_quotient", int'(bus.quotient), 0);
        chk("mid_rst_remainder", int'(bus.remainder), 0);
        @(posedge clk);
        #1;
        run_dir(vt[10]);

        // Random operands with idle gaps and random hold-off before taking
        a0 = n_acc;
        o0 = n_out;
        for (int i = 0; i < 1500; i++) begin
            a = int'($signed(16'($urandom)));
            b = int'($signed(8'($urandom)));
            sel = int'($urandom_range(0, 15));
            if (sel == 0) b = 0;
            if (sel == 1) begin a = -32768; b = -1; end
            if (sel == 2) a = -32768;
            if (sel == 3) b = -128;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(a, b);
            wait_valid(lat);
            take(int'($urandom_range(0, 3)));
        end
        @(negedge clk);
        chk("rand_accepted", n_acc - a0, 1500);
        chk("rand_delivered", n_out - o0, 1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
